// File: rtl/dmem_lsu_master_if.sv
// Core-request, response and data-memory signal bundle for the LSU.
// master: LSU side; slave: core + memory side.
interface dmem_lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_fault, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_fault, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_lsu_master.sv
// RV32I load/store unit driving a word-addressed single-port data memory.
// Ports: clk, rst (sync, active high), bus (dmem_lsu_master_if.master).
// Optional LSU_RANGE_CHECK_EN: address bits above the memory fault.
module dmem_lsu_master #(
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst,
  dmem_lsu_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RMW_RD, RMW_WR, RESP
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        acc;
  logic [2:0]  f3;
  logic [31:0] a;
  logic        is_h, is_w;
  logic        legal, mis, oor, fault;
  logic        c_flt, c_rd, c_wr, c_rmw;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;
  logic [31:0] merged;

  assign acc = bus.req_valid && (state_q == IDLE);
  assign f3  = bus.req_funct3;
  assign a   = bus.req_addr;

  assign is_h = (f3[1:0] == 2'b01);
  assign is_w = (f3 == 3'b010);

  // Stores only have B/H/W encodings; BU/HU are load-only.
  assign legal = bus.req_we ? (f3 inside {3'b000, 3'b001, 3'b010})
                            : (f3 inside {3'b000, 3'b001, 3'b010,
                                          3'b100, 3'b101});
  assign mis = (is_h && a[0]) || (is_w && (a[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
  assign oor = |a[31:ADDR_W+2];
`else
  logic [29-ADDR_W:0] unused_hi;
  assign unused_hi = a[31:ADDR_W+2];
  assign oor = 1'b0;
`endif

  assign fault = !legal || mis || oor;

  assign c_flt = fault;
  assign c_rd  = !fault && !bus.req_we;
  assign c_wr  = !fault && bus.req_we && is_w;
  assign c_rmw = !fault && bus.req_we && !is_w;

  assign byte_v = bus.mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_v = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    ext = bus.mem_rdata;
    unique case (f3_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b100:  ext = {24'b0, byte_v};
      3'b101:  ext = {16'b0, half_v};
      default: ext = bus.mem_rdata;
    endcase
  end

  // f3_q[0] separates SH from SB on the read-modify-write path.
  always_comb begin
    merged = bus.mem_rdata;
    if (f3_q[0])
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            c_flt: state_d = RESP;
            c_rd:  state_d = RD;
            c_wr:  state_d = WR;
            c_rmw: state_d = RMW_RD;
            default: state_d = RESP;
          endcase
        end
      end
      RD:      state_d = RESP;
      WR:      state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        f3_q    <= f3;
        lane_q  <= a[1:0];
        wdata_q <= bus.req_wdata;
        addr_q  <= {{(32-ADDR_W){1'b0}}, a[ADDR_W+1:2]};
        if (c_wr)
          mem_wdata_q <= bus.req_wdata;
        if (c_flt) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
      end
      unique case (state_q)
        RD: begin
          rdata_q <= ext;
          fault_q <= 1'b0;
        end
        WR, RMW_WR: begin
          rdata_q <= '0;
          fault_q <= 1'b0;
        end
        RMW_RD: mem_wdata_q <= merged;
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = (state_q == WR) || (state_q == RMW_WR);

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Directed bench for dmem_lsu_master with a response scoreboard.
// Memory model, latency/write-count checks and reset behaviour.
module tb_dmem_lsu_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_lsu_master_if bus();

  dmem_lsu_master #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [31:0] mem [0:1023];
  logic        tb_we   = 1'b0;
  logic [9:0]  tb_idx  = '0;
  logic [31:0] tb_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (tb_we)
      mem[tb_idx] <= tb_data;
    else if (bus.mem_we)
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  typedef struct {
    logic [31:0] rd;
    logic        f;
  } exp_t;
  exp_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we) begin
      we_cnt++;
      chk("mem_addr_hi", bus.mem_addr >> 10, 32'd0);
    end
    if (bus.resp_valid && !rst) begin
      chk("resp_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rd);
        chk("resp_fault", 32'(bus.resp_fault), 32'(e.f));
      end
    end
  end

  task automatic poke(input logic [9:0] idx, input logic [31:0] d);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_idx  = idx;
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  // Caller is at a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] exp_rd,
    input logic        exp_f,
    input int          exp_lat,
    input int          exp_wes
  );
    int guard;
    int lat;
    int w0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    q.push_back('{rd: exp_rd, f: exp_f});
    w0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_busy_resp"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_wes"}, we_cnt - w0, exp_wes);
  endtask

  initial begin
    int w0;
    int guard;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst = 1'b1;

    poke(10'd0, 32'h0BAD_F00D);
    poke(10'd1, 32'h8000_80F0);
    poke(10'd2, 32'h1122_3344);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req("lb",  1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 0);
    do_req("lbu", 1'b0, 3'b100, 32'h4, 32'h0, 32'h0000_00F0, 1'b0, 2, 0);
    do_req("lh",  1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_8000, 1'b0, 2, 0);
    do_req("lhu", 1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_8000, 1'b0, 2, 0);
    do_req("lw",  1'b0, 3'b010, 32'h4, 32'h0, 32'h8000_80F0, 1'b0, 2, 0);
    do_req("lb7", 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);

    do_req("sb", 1'b1, 3'b000, 32'h9, 32'h0000_00AB, 32'h0, 1'b0, 3, 1);
    chk("sb_mem", mem[2], 32'h1122_AB44);
    do_req("sh", 1'b1, 3'b001, 32'hA, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1);
    chk("sh_mem", mem[2], 32'hBEEF_AB44);

    do_req("lw_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("sh_mis", 1'b1, 3'b001, 32'h3, 32'h1234, 32'h0, 1'b1, 1, 0);
    do_req("ill_f3", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("mis_mem2", mem[2], 32'hBEEF_AB44);
    chk("mis_mem0", mem[0], 32'h0BAD_F00D);

    do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
    do_req("lw_b2b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h9;
    bus.req_wdata  = 32'h55;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    w0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wes", we_cnt - w0, 32'd0);
    chk("abort_mem", mem[2], 32'hBEEF_AB44);
    chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

`ifdef LSU_RANGE_CHECK_EN
    do_req("lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    do_req("lw_wrap", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
